// File: rtl/mult_ctrl_pkg.sv
// Shared sizes, payload types and helpers for the multiplier issue controller.
package mult_ctrl_pkg;

    localparam int unsigned NUM_REQ   = 3;
    localparam int unsigned MULT_LAT  = 4;
    localparam int unsigned RES_DEPTH = 4;
    localparam int unsigned TAG_W     = 6;
    localparam int unsigned DATA_W    = 64;

    localparam int unsigned RR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W  = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int unsigned FCNT_W = $clog2(RES_DEPTH + 1);
    localparam int unsigned OCC_W  = $clog2(RES_DEPTH + MULT_LAT + 1);
    localparam int unsigned RES_W  = TAG_W + DATA_W;

    typedef struct packed {
        logic [DATA_W-1:0] opa;
        logic [DATA_W-1:0] opb;
        logic [TAG_W-1:0]  tag;
    } mult_req_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } mult_res_t;

    // Number of live operations in the tag pipeline.
    function automatic logic [OCC_W-1:0] count_ones(input logic [MULT_LAT-1:0] i_bits);
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(MULT_LAT); i++) begin
            cnt = cnt + OCC_W'(i_bits[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mult_res_fifo.sv
// Result FIFO between the multiplier tag pipeline and the CDB; clear flushes everything.
module mult_res_fifo
    import mult_ctrl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [RES_W-1:0]  i_push_data,
    input  logic              i_pop,
    input  logic              i_clear,
    output logic [RES_W-1:0]  o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic [FCNT_W-1:0] o_count
);

    mult_res_t          r_mem [RES_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [FCNT_W-1:0]  r_count;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] i_ptr);
        return (i_ptr == PTR_W'(RES_DEPTH - 1)) ? '0 : i_ptr + PTR_W'(1);
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FCNT_W'(RES_DEPTH));
    assign w_pop   = i_pop && !w_empty && !i_clear;
    // A pop in the same cycle makes room, so a push while full is still accepted then.
    assign w_push  = i_push && !i_clear && (!w_full || w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FCNT_W'(1);
                2'b01:   r_count <= r_count - FCNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= mult_res_t'(i_push_data);
    end

    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue controller for an external fixed-latency multiplier: round-robin issue,
// credit-limited tag pipeline, result FIFO onto the CDB, squash and protocol checking.
module mult_issue_ctrl
    import mult_ctrl_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  i_req_opa,
    input  logic [NUM_REQ*DATA_W-1:0]  i_req_opb,
    input  logic [NUM_REQ*TAG_W-1:0]   i_req_tag,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic                       i_squash,
    output logic                       o_mult_start,
    output logic [DATA_W-1:0]          o_mult_mcand,
    output logic [DATA_W-1:0]          o_mult_mplier,
    input  logic                       i_mult_done,
    input  logic [DATA_W-1:0]          i_mult_product,
    output logic                       o_cdb_valid,
    output logic [TAG_W-1:0]           o_cdb_tag,
    output logic [DATA_W-1:0]          o_cdb_value,
    input  logic                       i_cdb_grant,
    output logic                       o_prot_err
);

    localparam int unsigned LAST = MULT_LAT - 1;

    mult_req_t          w_req [NUM_REQ];
    mult_req_t          w_sel;
    logic [NUM_REQ-1:0] w_grant;
    logic [RR_W-1:0]    w_gidx;
    logic               w_any;
    logic               w_issue_ok;
    logic [OCC_W-1:0]   w_occ;

    logic [RR_W-1:0]     r_rr;
    logic [MULT_LAT-1:0] r_issued;
    logic [MULT_LAT-1:0] r_live;
    logic [TAG_W-1:0]    r_tag [MULT_LAT];
    logic                r_prot_err;

    logic               w_push;
    logic               w_overflow;
    mult_res_t          w_push_res;
    mult_res_t          w_head;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [FCNT_W-1:0]  w_fifo_count;

    always_comb begin
        for (int w = 0; w < int'(NUM_REQ); w++) begin
            w_req[w].opa = i_req_opa[w*DATA_W +: DATA_W];
            w_req[w].opb = i_req_opb[w*DATA_W +: DATA_W];
            w_req[w].tag = i_req_tag[w*TAG_W +: TAG_W];
        end
    end

    // Credits count only registered state, so a pop frees its slot one cycle later.
    assign w_occ      = count_ones(r_live) + OCC_W'(w_fifo_count);
    assign w_issue_ok = !i_rst && !i_squash && (w_occ < OCC_W'(RES_DEPTH));

    always_comb begin : p_arb
        int v_idx;
        v_idx   = 0;
        w_grant = '0;
        w_gidx  = '0;
        w_any   = 1'b0;
        if (w_issue_ok) begin
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                v_idx = int'(r_rr) + k;
                if (v_idx >= int'(NUM_REQ)) v_idx = v_idx - int'(NUM_REQ);
                if (!w_any && i_req_valid[v_idx]) begin
                    w_any          = 1'b1;
                    w_gidx         = RR_W'(v_idx);
                    w_grant[v_idx] = 1'b1;
                end
            end
        end
    end

    assign w_sel         = w_req[w_gidx];
    assign o_req_ready   = w_grant;
    assign o_mult_start  = w_any;
    assign o_mult_mcand  = w_any ? w_sel.opa : '0;
    assign o_mult_mplier = w_any ? w_sel.opb : '0;

    assign w_push     = r_live[LAST] && !i_squash;
    assign w_push_res = '{tag: r_tag[LAST], value: i_mult_product};
    assign w_overflow = w_push && w_fifo_full && !(i_cdb_grant && !w_fifo_empty);

    // Issued bits ignore squash so stale done pulses from killed work stay legal.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr       <= '0;
            r_issued   <= '0;
            r_live     <= '0;
            r_prot_err <= 1'b0;
            for (int i = 0; i < int'(MULT_LAT); i++) r_tag[i] <= '0;
        end else begin
            r_issued <= {r_issued[LAST-1:0], w_any};
            r_live   <= i_squash ? '0 : {r_live[LAST-1:0], w_any};
            r_tag[0] <= w_any ? w_sel.tag : '0;
            for (int i = 1; i < int'(MULT_LAT); i++) r_tag[i] <= r_tag[i-1];
            if (w_any) begin
                r_rr <= (w_gidx == RR_W'(NUM_REQ - 1)) ? '0 : w_gidx + RR_W'(1);
            end
            if ((i_mult_done != r_issued[LAST]) || w_overflow) r_prot_err <= 1'b1;
        end
    end

    mult_res_fifo u_res_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_push),
        .i_push_data (w_push_res),
        .i_pop       (i_cdb_grant),
        .i_clear     (i_squash),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign o_cdb_valid = !w_fifo_empty;
    assign o_cdb_tag   = w_head.tag;
    assign o_cdb_value = w_head.value;
    assign o_prot_err  = r_prot_err;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl with a behavioural fixed-latency multiplier.
module tb_mult_issue_ctrl;
    import mult_ctrl_pkg::*;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_opa;
    logic [NUM_REQ*DATA_W-1:0] req_opb;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      squash;
    logic                      mult_start;
    logic [DATA_W-1:0]         mult_mcand;
    logic [DATA_W-1:0]         mult_mplier;
    logic                      mult_done;
    logic [DATA_W-1:0]         mult_product;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_value;
    logic                      cdb_grant;
    logic                      prot_err;
    logic                      inj_done;

    int n_tests;
    int n_fail;

    logic [MULT_LAT-1:0] m_v;
    logic [DATA_W-1:0]   m_p [MULT_LAT];
    logic [NUM_REQ-1:0]  exp_rdy [8];

    mult_issue_ctrl dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .i_req_opa      (req_opa),
        .i_req_opb      (req_opb),
        .i_req_tag      (req_tag),
        .o_req_ready    (req_ready),
        .i_squash       (squash),
        .o_mult_start   (mult_start),
        .o_mult_mcand   (mult_mcand),
        .o_mult_mplier  (mult_mplier),
        .i_mult_done    (mult_done),
        .i_mult_product (mult_product),
        .o_cdb_valid    (cdb_valid),
        .o_cdb_tag      (cdb_tag),
        .o_cdb_value    (cdb_value),
        .i_cdb_grant    (cdb_grant),
        .o_prot_err     (prot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: done and product exactly MULT_LAT cycles after start.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v <= '0;
            for (int i = 0; i < int'(MULT_LAT); i++) m_p[i] <= '0;
        end else begin
            m_v    <= {m_v[MULT_LAT-2:0], mult_start};
            m_p[0] <= mult_mcand * mult_mplier;
            for (int i = 1; i < int'(MULT_LAT); i++) m_p[i] <= m_p[i-1];
        end
    end
    assign mult_done    = m_v[MULT_LAT-1] | inj_done;
    assign mult_product = m_p[MULT_LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_way(input int w, input logic [63:0] a, input logic [63:0] b,
                           input logic [TAG_W-1:0] t);
        req_opa[w*DATA_W +: DATA_W] = a;
        req_opb[w*DATA_W +: DATA_W] = b;
        req_tag[w*TAG_W +: TAG_W]   = t;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        squash    = 1'b0;
        cdb_grant = 1'b0;
        inj_done  = 1'b0;
        req_valid = '1;
        for (int w = 0; w < int'(NUM_REQ); w++) set_way(w, 64'h11, 64'h22, TAG_W'(w + 1));
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_start", 64'(mult_start), 64'd0);
        check("rst_mcand", mult_mcand, 64'd0);
        check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst_cdb_tag", 64'(cdb_tag), 64'd0);
        check("rst_cdb_value", cdb_value, 64'd0);
        check("rst_prot_err", 64'(prot_err), 64'd0);
        tick();
        tick();
        req_valid = '0;
        rst       = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; squash = 1'b0; cdb_grant = 1'b0; inj_done = 1'b0;
        req_valid = '0; req_opa = '0; req_opb = '0; req_tag = '0;

        // Single issue on way 1: result on the CDB exactly 5 cycles later, once.
        do_reset();
        cdb_grant = 1'b1;
        set_way(1, 64'd3, 64'd5, 6'd9);
        req_valid = 3'b010;
        #1;
        check("lat_ready", 64'(req_ready), 64'b010);
        check("lat_start", 64'(mult_start), 64'd1);
        check("lat_mcand", mult_mcand, 64'd3);
        check("lat_mplier", mult_mplier, 64'd5);
        tick();
        req_valid = '0;
        for (int k = 1; k <= 7; k++) begin
            #1;
            check($sformatf("lat_cdb_valid_c%0d", k), 64'(cdb_valid), 64'(k == 5));
            if (k == 5) begin
                check("lat_cdb_tag", 64'(cdb_tag), 64'd9);
                check("lat_cdb_value", cdb_value, 64'd15);
            end
            tick();
        end
        check("lat_prot_err", 64'(prot_err), 64'd0);

        // All ways requesting: round robin 0,1,2,0 then stall at 4 credits.
        do_reset();
        cdb_grant = 1'b1;
        for (int w = 0; w < int'(NUM_REQ); w++) set_way(w, 64'(w + 2), 64'd7, TAG_W'(10 + w));
        exp_rdy = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000, 3'b010, 3'b100};
        req_valid = 3'b111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("rr_ready_c%0d", k), 64'(req_ready), 64'(exp_rdy[k]));
            if (k == 5) begin
                check("rr_cdb_valid", 64'(cdb_valid), 64'd1);
                check("rr_cdb_tag", 64'(cdb_tag), 64'd10);
                check("rr_cdb_value", cdb_value, 64'd14);
            end
            tick();
        end
        req_valid = '0;
        for (int k = 0; k < 8; k++) tick();
        #1;
        check("rr_drained", 64'(cdb_valid), 64'd0);
        check("rr_prot_err", 64'(prot_err), 64'd0);

        // FIFO fills with no CDB grant; the fifth request waits for a pop plus one cycle.
        do_reset();
        req_valid = 3'b001;
        for (int k = 0; k < 4; k++) begin
            set_way(0, 64'(k + 1), 64'd10, TAG_W'(k + 1));
            #1;
            check($sformatf("full_issue_c%0d", k), 64'(req_ready), 64'b001);
            tick();
        end
        set_way(0, 64'd5, 64'd10, 6'd5);
        for (int k = 4; k <= 8; k++) begin
            #1;
            check($sformatf("full_stall_c%0d", k), 64'(req_ready), 64'b000);
            if (k == 8) check("full_cdb_valid", 64'(cdb_valid), 64'd1);
            tick();
        end
        cdb_grant = 1'b1;
        #1;
        check("full_pop_cycle_ready", 64'(req_ready), 64'b000);
        check("full_head_tag", 64'(cdb_tag), 64'd1);
        check("full_head_value", cdb_value, 64'd10);
        tick();
        cdb_grant = 1'b0;
        #1;
        check("full_after_pop_ready", 64'(req_ready), 64'b001);
        check("full_next_tag", 64'(cdb_tag), 64'd2);
        check("full_next_value", cdb_value, 64'd20);
        tick();
        req_valid = '0;

        // Squash with two buffered and two in flight; killed done pulses are harmless.
        do_reset();
        req_valid = 3'b001;
        for (int k = 0; k < 4; k++) begin
            set_way(0, 64'(k + 1), 64'd3, TAG_W'(k + 1));
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        squash    = 1'b1;
        cdb_grant = 1'b1;
        #1;
        check("sq_pre_cdb_valid", 64'(cdb_valid), 64'd1);
        check("sq_pre_cdb_tag", 64'(cdb_tag), 64'd1);
        tick();
        squash    = 1'b0;
        cdb_grant = 1'b0;
        for (int k = 7; k <= 12; k++) begin
            #1;
            check($sformatf("sq_cdb_valid_c%0d", k), 64'(cdb_valid), 64'd0);
            tick();
        end
        check("sq_prot_err", 64'(prot_err), 64'd0);
        squash    = 1'b1;
        req_valid = 3'b010;
        #1;
        check("sq_blocks_grant", 64'(req_ready), 64'b000);
        tick();
        squash = 1'b0;
        #1;
        check("sq_release_grant", 64'(req_ready), 64'b010);
        tick();
        req_valid = '0;

        // Spurious mult_done sets a sticky protocol error.
        do_reset();
        inj_done = 1'b1;
        #1;
        check("err_before_edge", 64'(prot_err), 64'd0);
        tick();
        inj_done = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check($sformatf("err_sticky_c%0d", k), 64'(prot_err), 64'd1);
            tick();
        end
        do_reset();
        #1;
        check("err_cleared", 64'(prot_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
